fb_scanout: RTL and testbench
=============================

// Module: fb_scanout
//
// PURPOSE
//   Framebuffer scan-out stage between the VGA timing generator and the VGA pixel driver.
//   - Walks the 320x240 RGB332 framebuffer with counters, replacing the (Y/2)*320+(X/2)
//     multiply/divide, and scales each source pixel 2x horizontally and vertically.
//   - Issues read addresses to the GPU port of the framebuffer memory.
//   - Aligns the returned bytes with the display-active strobe.
//   - Expands each byte to 4:4:4 colour for the driver.
//
// PARAMETERS
//   SRC_W         320   source pixels per line
//   SRC_H         240   source lines per frame
//   BASE_ADDR     0     framebuffer byte address of pixel (0,0)
//   READ_LATENCY  1     cycles from MemAddress to valid MemData (1..4)
//
// PORTS
//   Clock       in   1   pixel clock (GPU clock domain)
//   Reset_n     in   1   synchronous active-low reset
//   FrameStart  in   1   one-cycle pulse before first active pixel of a frame
//   Active      in   1   display-active strobe from timing generator (high for 640 cycles/line)
//   MemAddress  out  32  framebuffer read address
//   MemData     in   8   RGB332 byte, valid READ_LATENCY cycles after its address
//   ColorR      out  4   red   = {MemData[7:5],1'b0}
//   ColorG      out  4   green = {MemData[4:2],1'b0}
//   ColorB      out  4   blue  = {MemData[1:0],2'b00}
//   ColorValid  out  1   Active delayed by READ_LATENCY+1 cycles
//   Overrun     out  1   sticky: more than 2*SRC_H lines seen since FrameStart
//
// BEHAVIOUR
//   - Reset (Reset_n=0 at a clock edge):
//       - LineBase=BASE_ADDR; SrcCol=0, HalfPix=0, LineOdd=0, LineCnt=0.
//       - Delay pipe cleared; ColorR/G/B=0, ColorValid=0, Overrun=0.
//       - MemAddress=BASE_ADDR.
//   - MemAddress = LineBase + SrcCol, combinational from registers; 32-bit, wraps mod 2^32.
//   - While Active=1, each cycle:
//       - HalfPix toggles.
//       - When HalfPix was 1, SrcCol++ (saturates at SRC_W-1, never wraps mid-line).
//   - End of line (Active 1->0, detected with a registered copy of Active):
//       - SrcCol=0, HalfPix=0, LineOdd toggles.
//       - If LineOdd was 1, LineBase += SRC_W.
//       - LineCnt++ (saturates at 2*SRC_H).
//   - FrameStart=1: LineBase=BASE_ADDR; SrcCol, HalfPix, LineOdd, LineCnt=0; Overrun=0.
//       - FrameStart wins over a simultaneous end-of-line and over Active.
//   - Lines beyond 2*SRC_H:
//       - LineBase stops advancing.
//       - Output colour is forced to 0; ColorValid timing is unchanged.
//       - Overrun is set and holds until the next FrameStart or reset.
//   - Pipeline:
//       - Active (and the blank-force flag) pass through a shift register of depth READ_LATENCY.
//       - Colour and ColorValid are then registered.
//       - Total latency Active -> ColorValid = READ_LATENCY+1 cycles.
//   - Colour output:
//       - When the delayed Active = 0, ColorR/G/B = 0 (blanked).
//       - When the delayed Active = 1 and not forced, ColorR/G/B = expansion of MemData.
//   - Reset mid-line: all state clears; outputs are 0 on the next cycle.
//       - Scan-out resumes correctly only after the next FrameStart.
//   - No backpressure: the memory must accept one address per cycle.
//
// TESTING
//   1. Reset: Reset_n=0 two cycles with random inputs -> MemAddress=BASE_ADDR, all colour outputs 0, ColorValid=0, Overrun=0.
//   2. Line 0: FrameStart then 640 Active cycles -> MemAddress sequence 0,0,1,1,...,319,319; ColorValid rises exactly READ_LATENCY+1 cycles after Active.
//   3. Vertical scale: lines 0 and 1 both start at address 0; line 2 starts at 320; line 479 starts at 239*320=76480.
//   4. Colour expansion: MemData=8'hE3 -> R=4'hE, G=4'h0, B=4'hC; MemData=8'h1C -> R=0, G=4'hE, B=0.
//   5. Overrun: 481 lines without FrameStart -> line 481 outputs colour 0, LineBase held, Overrun=1; next FrameStart clears Overrun and restarts at 0.
//   6. Corner events: FrameStart coincident with end-of-line -> LineBase=BASE_ADDR, not +320; Reset_n low at pixel 100 of line 5 -> outputs 0 next cycle, clean restart after FrameStart; repeat with READ_LATENCY=3.

Source files
------------

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : fb_scanout
// Purpose  : Framebuffer scan-out. Walks a 320x240 RGB332 buffer with 2x
//            pixel/line replication and delivers 4:4:4 colour to the driver.
// Revision : 1.0 - initial release
// ============================================================================
module fb_scanout #(
    parameter int          SRC_W        = 320,
    parameter int          SRC_H        = 240,
    parameter logic [31:0] BASE_ADDR    = 32'd0,
    parameter int          READ_LATENCY = 1
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        FrameStart,
    input  logic        Active,
    output logic [31:0] MemAddress,
    input  logic [7:0]  MemData,
    output logic [3:0]  ColorR,
    output logic [3:0]  ColorG,
    output logic [3:0]  ColorB,
    output logic        ColorValid,
    output logic        Overrun
);

    localparam int c_col_w = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int c_cnt_w = $clog2(2 * SRC_H + 1);

    localparam logic [c_col_w-1:0] c_col_last  = c_col_w'(SRC_W - 1);
    localparam logic [c_cnt_w-1:0] c_line_max  = c_cnt_w'(2 * SRC_H);
    localparam logic [c_cnt_w-1:0] c_line_last = c_cnt_w'(2 * SRC_H - 1);
    localparam logic [31:0]        c_line_step = 32'(SRC_W);

    logic [31:0]        r_line_base;
    logic [c_col_w-1:0] r_src_col;
    logic               r_half_pix;
    logic               r_line_odd;
    logic [c_cnt_w-1:0] r_line_cnt;
    logic               r_active_q;
    logic               r_overrun;

    logic [READ_LATENCY-1:0] r_act_pipe;
    logic [READ_LATENCY-1:0] r_force_pipe;

    logic               w_eol;
    logic               w_force;
    logic               w_act_d;
    logic               w_force_d;

    assign w_eol      = r_active_q & ~Active;
    assign w_force    = (r_line_cnt == c_line_max);
    assign w_act_d    = r_act_pipe[READ_LATENCY-1];
    assign w_force_d  = r_force_pipe[READ_LATENCY-1];

    assign MemAddress = r_line_base + 32'(r_src_col);
    assign Overrun    = r_overrun;

    // Address walker: one source pixel per two display pixels, one source
    // line per two display lines.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_line_base <= BASE_ADDR;
            r_src_col   <= '0;
            r_half_pix  <= 1'b0;
            r_line_odd  <= 1'b0;
            r_line_cnt  <= '0;
            r_active_q  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_active_q <= Active;
            if (FrameStart) begin
                r_line_base <= BASE_ADDR;
                r_src_col   <= '0;
                r_half_pix  <= 1'b0;
                r_line_odd  <= 1'b0;
                r_line_cnt  <= '0;
                r_overrun   <= 1'b0;
            end else if (w_eol) begin
                r_src_col  <= '0;
                r_half_pix <= 1'b0;
                r_line_odd <= ~r_line_odd;
                // Freeze the base on the last legal source line so overrun
                // lines never read past the buffer.
                if (r_line_odd && (r_line_cnt < c_line_last)) begin
                    r_line_base <= r_line_base + c_line_step;
                end
                if (r_line_cnt != c_line_max) begin
                    r_line_cnt <= r_line_cnt + 1'b1;
                end
            end else if (Active) begin
                r_half_pix <= ~r_half_pix;
                if (r_half_pix && (r_src_col != c_col_last)) begin
                    r_src_col <= r_src_col + 1'b1;
                end
                if (w_force) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    // Strobe alignment with the memory read latency.
    generate
        if (READ_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge Clock) begin
                if (!Reset_n) begin
                    r_act_pipe   <= '0;
                    r_force_pipe <= '0;
                end else begin
                    r_act_pipe   <= Active;
                    r_force_pipe <= w_force;
                end
            end
        end else begin : g_pipe_shift
            always_ff @(posedge Clock) begin
                if (!Reset_n) begin
                    r_act_pipe   <= '0;
                    r_force_pipe <= '0;
                end else begin
                    r_act_pipe   <= {r_act_pipe[READ_LATENCY-2:0], Active};
                    r_force_pipe <= {r_force_pipe[READ_LATENCY-2:0], w_force};
                end
            end
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            ColorR     <= 4'h0;
            ColorG     <= 4'h0;
            ColorB     <= 4'h0;
            ColorValid <= 1'b0;
        end else begin
            ColorValid <= w_act_d;
            if (w_act_d && !w_force_d) begin
                ColorR <= {MemData[7:5], 1'b0};
                ColorG <= {MemData[4:2], 1'b0};
                ColorB <= {MemData[1:0], 2'b00};
            end else begin
                ColorR <= 4'h0;
                ColorG <= 4'h0;
                ColorB <= 4'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_scanout
// Purpose  : Directed bench for fb_scanout at read latencies 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        active;

    logic [31:0] addr1, addr3;
    logic [7:0]  md1, md3, m3a, m3b;
    logic [3:0]  r1, g1, b1, r3, g3, b3;
    logic        cv1, cv3, ov1, ov3;

    bit          fixed_mode;
    logic [7:0]  fixed_byte;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fb_scanout #(.SRC_W(320), .SRC_H(240), .BASE_ADDR(32'd0), .READ_LATENCY(1)) u_dut_l1 (
        .Clock(clk), .Reset_n(rst_n), .FrameStart(frame_start), .Active(active),
        .MemAddress(addr1), .MemData(md1),
        .ColorR(r1), .ColorG(g1), .ColorB(b1), .ColorValid(cv1), .Overrun(ov1)
    );

    fb_scanout #(.SRC_W(320), .SRC_H(240), .BASE_ADDR(32'd0), .READ_LATENCY(3)) u_dut_l3 (
        .Clock(clk), .Reset_n(rst_n), .FrameStart(frame_start), .Active(active),
        .MemAddress(addr3), .MemData(md3),
        .ColorR(r3), .ColorG(g3), .ColorB(b3), .ColorValid(cv3), .Overrun(ov3)
    );

    function automatic logic [7:0] mem_fn(input logic [31:0] a);
        return fixed_mode ? fixed_byte : (a[7:0] ^ 8'hA5);
    endfunction

    function automatic logic [11:0] expand(input logic [7:0] d);
        return {d[7:5], 1'b0, d[4:2], 1'b0, d[1:0], 2'b00};
    endfunction

    // Framebuffer memory model: registered read, 1 and 3 cycles deep.
    always @(posedge clk) begin
        md1 <= mem_fn(addr1);
        m3a <= mem_fn(addr3);
        m3b <= m3a;
        md3 <= m3b;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive n active cycles on a line whose source base is `base`.
    task automatic drive_pixels(input int n, input logic [31:0] base, input bit blank);
        logic [11:0] e;
        for (int p = 0; p < n; p++) begin
            active = 1'b1;
            check("addr_l1", addr1, base + 32'(p / 2));
            check("addr_l3", addr3, base + 32'(p / 2));
            tick();
            if (p < 5) begin
                check("cv_rise_l1", 32'(cv1), (p + 1 >= 2) ? 32'd1 : 32'd0);
                check("cv_rise_l3", 32'(cv3), (p + 1 >= 4) ? 32'd1 : 32'd0);
            end
            if (p >= 3) begin
                e = blank ? 12'h000 : expand(mem_fn(base + 32'((p - 1) / 2)));
                check("color_l1", 32'({r1, g1, b1}), 32'(e));
                e = blank ? 12'h000 : expand(mem_fn(base + 32'((p - 3) / 2)));
                check("color_l3", 32'({r3, g3, b3}), 32'(e));
            end
        end
    endtask

    task automatic end_line;
        active = 1'b0;
        repeat (5) tick();
        check("blank_cv_l1", 32'(cv1), 32'd0);
        check("blank_cv_l3", 32'(cv3), 32'd0);
        check("blank_rgb_l1", 32'({r1, g1, b1}), 32'd0);
        check("blank_rgb_l3", 32'({r3, g3, b3}), 32'd0);
    endtask

    task automatic pulse_frame_start;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        active      = 1'b0;
        fixed_mode  = 1'b0;
        fixed_byte  = 8'h00;

        // Reset with random strobes
        for (int i = 0; i < 2; i++) begin
            frame_start = 1'($urandom_range(0, 1));
            active      = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_addr_l1", addr1, 32'd0);
        check("rst_addr_l3", addr3, 32'd0);
        check("rst_rgb_l1", 32'({r1, g1, b1}), 32'd0);
        check("rst_rgb_l3", 32'({r3, g3, b3}), 32'd0);
        check("rst_cv_l1", 32'(cv1), 32'd0);
        check("rst_cv_l3", 32'(cv3), 32'd0);
        check("rst_ov_l1", 32'(ov1), 32'd0);
        check("rst_ov_l3", 32'(ov3), 32'd0);

        rst_n       = 1'b1;
        frame_start = 1'b0;
        active      = 1'b0;
        repeat (2) tick();
        pulse_frame_start();

        // Two full display lines from source line 0
        drive_pixels(640, 32'd0, 1'b0);
        end_line();
        drive_pixels(640, 32'd0, 1'b0);
        end_line();

        // Colour expansion on source line 1
        fixed_mode = 1'b1;
        fixed_byte = 8'hE3;
        check("line2_base", addr1, 32'd320);
        drive_pixels(8, 32'd320, 1'b0);
        check("e3_l1", 32'({r1, g1, b1}), 32'h0E0C);
        check("e3_l3", 32'({r3, g3, b3}), 32'h0E0C);
        end_line();
        fixed_byte = 8'h1C;
        drive_pixels(8, 32'd320, 1'b0);
        check("1c_l1", 32'({r1, g1, b1}), 32'h00E0);
        check("1c_l3", 32'({r3, g3, b3}), 32'h00E0);
        end_line();
        fixed_mode = 1'b0;
        check("no_ov_l1", 32'(ov1), 32'd0);

        // Remaining lines of the frame, short strobes
        for (int ln = 4; ln < 480; ln++) begin
            if (ln == 479) check("line479_base", addr1, 32'd76480);
            drive_pixels(2, 32'((ln / 2) * 320), 1'b0);
            end_line();
        end

        // Overrun lines: held base, forced black, valid still flowing
        drive_pixels(8, 32'd76480, 1'b1);
        end_line();
        check("ov_set_l1", 32'(ov1), 32'd1);
        check("ov_set_l3", 32'(ov3), 32'd1);
        drive_pixels(2, 32'd76480, 1'b1);
        end_line();
        check("ov_hold_l1", 32'(ov1), 32'd1);

        pulse_frame_start();
        check("ov_clr_l1", 32'(ov1), 32'd0);
        check("ov_clr_l3", 32'(ov3), 32'd0);
        check("fs_addr_l1", addr1, 32'd0);
        drive_pixels(8, 32'd0, 1'b0);
        end_line();

        // FrameStart coincident with end of an odd line
        drive_pixels(4, 32'd0, 1'b0);
        active      = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("fs_eol_l1", addr1, 32'd0);
        check("fs_eol_l3", addr3, 32'd0);
        repeat (4) tick();
        drive_pixels(4, 32'd0, 1'b0);
        end_line();
        drive_pixels(4, 32'd0, 1'b0);
        end_line();
        drive_pixels(4, 32'd320, 1'b0);
        end_line();
        drive_pixels(4, 32'd320, 1'b0);
        end_line();
        drive_pixels(4, 32'd640, 1'b0);
        end_line();

        // Reset at pixel 100 of line 5
        drive_pixels(100, 32'd640, 1'b0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_addr_l1", addr1, 32'd0);
        check("mid_rst_addr_l3", addr3, 32'd0);
        check("mid_rst_rgb_l1", 32'({r1, g1, b1}), 32'd0);
        check("mid_rst_rgb_l3", 32'({r3, g3, b3}), 32'd0);
        check("mid_rst_cv_l1", 32'(cv1), 32'd0);
        check("mid_rst_cv_l3", 32'(cv3), 32'd0);
        rst_n  = 1'b1;
        active = 1'b0;
        repeat (3) tick();
        pulse_frame_start();
        drive_pixels(8, 32'd0, 1'b0);
        end_line();
        drive_pixels(4, 32'd0, 1'b0);
        end_line();
        drive_pixels(4, 32'd320, 1'b0);
        end_line();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
